// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer and the main ALU interface.
// Opcode encodings match the EX-stage ALU decoder.
package alu_mul_sequencer_pkg;

    localparam int DEF_WIDTH = 64;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add MUL (low WIDTH bits) that borrows the shared ALU for the accumulate add.
// Latency k+1 cycles with continuous grant; result held in DONE until resp_ready.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_operand,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH);

    seq_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             iterate;
    logic             zero_op;
    logic             last_iter;
    logic [WIDTH-1:0] mplier_nxt;

    assign accept     = (state == IDLE) && req_valid && !flush;
    assign iterate    = (state == RUN) && alu_gnt && !flush;
    assign zero_op    = (req_a == '0) || (req_b == '0);
    assign mplier_nxt = mplier >> 1;
    // Early exit looks at the multiplier after this iteration's shift.
    assign last_iter  = ((EARLY_EXIT != 0) && (mplier_nxt == '0)) ||
                        (cnt == CNT_W'(WIDTH - 1));

    // ALU operands are always driven; the pipeline mux qualifies with alu_req & alu_gnt.
    assign alu_op1     = acc;
    assign alu_op2     = mcand;
    assign alu_operand = ALU_ADD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            alu_req     <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            alu_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (zero_op) begin
                            state <= DONE;
                        end else begin
                            state   <= RUN;
                            alu_req <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (alu_gnt && last_iter) begin
                        state   <= DONE;
                        alu_req <= 1'b0;
                    end
                end
                DONE: begin
                    // Response registers one cycle after entering DONE; pop only once visible.
                    if (resp_valid && resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end else begin
                        resp_valid  <= 1'b1;
                        resp_result <= acc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    alu_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            cnt    <= '0;
        end else if (iterate) begin
            if (mplier[0]) begin
                acc <= alu_out;
            end
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: a bench-side ALU adder, expected products queued at
// acceptance and compared when the response pops, plus latency, stall, backpressure, flush and reset checks.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         alu_req;
    logic         alu_gnt;
    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic [2:0]   alu_operand;
    logic [W-1:0] alu_out;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    // Main ALU stand-in: only ADD is ever requested.
    assign alu_out = alu_op1 + alu_op2;

    alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_operand(alu_operand), .alu_out(alu_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int iters(input logic [W-1:0] b);
        int k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // mode: 0 = grant always high, 1 = grant low on alternate RUN cycles
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                          input int bp_cycles, input string name);
        int lat, run_cycles, exp_lat, k;
        logic [W-1:0] exp, prev_op1, prev_op2;
        logic prev_gnt_low;
        k = iters(b);
        if (a == '0 || b == '0) k = 0;
        exp_lat = (k == 0) ? 1 : ((mode == 1) ? 2 * k + 1 : k + 1);
        exp = a * b;

        @(negedge clk);
        chk({name, "_req_ready"}, W'(req_ready), W'(1));
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        sb_q.push_back(exp);
        lat = 0;
        run_cycles = 0;
        prev_gnt_low = 1'b0;
        prev_op1 = '0;
        prev_op2 = '0;
        while (!resp_valid && lat < 200) begin
            if (prev_gnt_low && alu_req) begin
                chk({name, "_hold_op1"}, alu_op1, prev_op1);
                chk({name, "_hold_op2"}, alu_op2, prev_op2);
            end
            if (alu_req) run_cycles++;
            alu_gnt = (mode == 1) ? lat[0] : 1'b1;
            prev_gnt_low = !alu_gnt;
            prev_op1 = alu_op1;
            prev_op2 = alu_op2;
            @(negedge clk);
            lat++;
        end
        alu_gnt = 1'b0;
        chk({name, "_latency"}, W'(lat), W'(exp_lat));
        chk({name, "_run_cycles"}, W'(run_cycles), W'(exp_lat - 1));

        for (int i = 0; i < bp_cycles; i++) begin
            chk({name, "_bp_valid"}, W'(resp_valid), W'(1));
            chk({name, "_bp_result"}, resp_result, exp);
            chk({name, "_bp_req_ready"}, W'(req_ready), W'(0));
            @(negedge clk);
        end

        resp_ready = 1'b1;
        if (resp_valid && sb_q.size() > 0) begin
            chk({name, "_result"}, resp_result, sb_q.pop_front());
        end else begin
            chk({name, "_resp_missing"}, W'(resp_valid), W'(1));
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk({name, "_post_valid"}, W'(resp_valid), W'(0));
        chk({name, "_post_req_ready"}, W'(req_ready), W'(1));
    endtask

    // Starts 9x9, kills it on the 2nd RUN cycle by flush (use_rst=0) or reset (use_rst=1).
    task automatic kill_mid_run(input bit use_rst, input string name);
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 64'd9;
        req_b = 64'd9;
        @(negedge clk);
        req_valid = 1'b0;
        alu_gnt = 1'b1;
        @(negedge clk);
        chk({name, "_in_run"}, W'(alu_req), W'(1));
        if (use_rst) rst_n = 1'b0;
        else flush = 1'b1;
        @(negedge clk);
        chk({name, "_alu_req"}, W'(alu_req), W'(0));
        chk({name, "_req_ready"}, W'(req_ready), W'(1));
        chk({name, "_resp_valid"}, W'(resp_valid), W'(0));
        if (use_rst) begin
            chk({name, "_resp_result"}, resp_result, '0);
            chk({name, "_op1"}, alu_op1, '0);
            chk({name, "_op2"}, alu_op2, '0);
        end
        rst_n = 1'b1;
        flush = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid || alu_req) seen = 1'b1;
        end
        resp_ready = 1'b0;
        alu_gnt = 1'b0;
        chk({name, "_no_resp"}, W'(seen), W'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        alu_gnt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", W'(req_ready), W'(1));
        chk("rst_resp_valid", W'(resp_valid), W'(0));
        chk("rst_resp_result", resp_result, '0);
        chk("rst_alu_req", W'(alu_req), W'(0));
        chk("rst_op1", alu_op1, '0);
        chk("alu_opcode", W'(alu_operand), W'(ALU_ADD));
        rst_n = 1'b1;

        do_mul(64'd3, 64'd5, 0, 0, "mul3x5");
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "wrap_ones");
        do_mul(64'h8000_0000_0000_0000, 64'd2, 0, 0, "wrap_msb");
        do_mul(64'h1234, 64'd0, 0, 0, "zero_b");
        do_mul(64'd0, 64'h55, 0, 0, "zero_a");
        do_mul(64'd7, 64'd6, 1, 0, "stall7x6");
        do_mul(64'd7, 64'd6, 0, 5, "bp7x6");
        do_mul(64'd7, 64'd6, 0, 0, "back2back");
        for (int i = 0; i < 4; i++) begin
            do_mul({$urandom, $urandom}, 64'($urandom_range(1, 1000)), i % 2, i, "rand");
        end

        // Request coincident with flush is not accepted.
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 64'd3;
        req_b = 64'd5;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        chk("flush_mask_alu_req", W'(alu_req), W'(0));
        chk("flush_mask_req_ready", W'(req_ready), W'(1));

        kill_mid_run(1'b0, "flush_run");
        kill_mid_run(1'b1, "reset_run");
        do_mul(64'd3, 64'd5, 0, 0, "recover");
        chk("sb_empty", W'(sb_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
